// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared constants and types for the RV32I core slice.
//   XLEN / ILEN       : address and instruction widths
//   RESET_VECTOR      : first fetch address after reset
//   FETCH_BUF_DEPTH   : entries in the fetch buffer between fetch and decode
//   fetch_entry_t     : one fetched instruction tagged with its address
//   fetch_state_t     : fetch control state, also exported for observation
//   word_align()      : clears the low two address bits
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR    = 32'h0000_0000;
  localparam int              FETCH_BUF_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: circular FIFO of fetch_entry_t between instruction memory and decode.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write wr_entry at the tail (ignored when full unless popping)
//   pop       : retire the head entry (ignored when empty)
//   flush     : drop every entry; wins over push and pop
//   wr_entry  : entry to write
//   rd_entry  : head entry (meaningful only while count != 0)
//   count     : number of valid entries, 0..DEPTH
module fetch_buf
  import rv32i_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 wr_entry,
  output fetch_entry_t                 rd_entry,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             do_push;
  logic             do_pop;

  // A full buffer can still accept a push in the same cycle it pops.
  assign do_pop  = pop & (count != '0);
  assign do_push = push & ((count != FULL) | do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= (tail == LAST) ? '0 : tail + PTR_W'(1);
      if (do_pop)  head <= (head == LAST) ? '0 : head + PTR_W'(1);
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[tail] <= wr_entry;
  end

  assign rd_entry = mem[head];

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch. Issues word-aligned reads to instruction memory,
// buffers the one-cycle-latency responses in fetch_buf and hands them to decode.
//   clk_in, rst_in          : clock, synchronous active-high reset
//   imem_req_out/addr_out   : read request and its address (always fetch_pc)
//   imem_rvalid_in/rdata_in : response, exactly one cycle after a request
//   redirect_in/redirect_pc_in : flush and restart fetch at the aligned target
//   valid_out/ready_in      : handshake toward decode
//   instr_out/pc_out        : head instruction and its address
//   state_out               : current fetch control state
//
// Handshake: an instruction transfers in a cycle where valid_out & ready_in.
// While valid_out is high and ready_in low, valid_out, instr_out and pc_out
// hold their values. valid_out never depends on ready_in; imem_req_out may.
module if_stage
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = rv32i_pkg::RESET_VECTOR,
  parameter int              BUF_DEPTH    = rv32i_pkg::FETCH_BUF_DEPTH
) (
  input  logic              clk_in,
  input  logic              rst_in,
  output logic              imem_req_out,
  output logic [XLEN-1:0]   imem_addr_out,
  input  logic              imem_rvalid_in,
  input  logic [ILEN-1:0]   imem_rdata_in,
  input  logic              redirect_in,
  input  logic [XLEN-1:0]   redirect_pc_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [ILEN-1:0]   instr_out,
  output logic [XLEN-1:0]   pc_out,
  output fetch_state_t      state_out
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(BUF_DEPTH);

  fetch_state_t   state;
  fetch_state_t   state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic            inflight;
  logic            push;
  logic            pop;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  fetch_entry_t     head_entry;
  fetch_entry_t     new_entry;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_BOOT;
    endcase
  end

  assign state_out = state;

  // Slots already committed: buffered entries plus the outstanding response,
  // minus the entry leaving this cycle. A new request is allowed only if its
  // response is guaranteed a slot.
  assign occupancy = {1'b0, count}
                   + {{CNT_W{1'b0}}, inflight}
                   - {{CNT_W{1'b0}}, pop};

  assign imem_req_out  = (state == ST_RUN) & ~redirect_in & (occupancy < DEPTH_LIM);
  assign imem_addr_out = fetch_pc;

  assign valid_out = (count != '0) & ~redirect_in;
  assign pop       = valid_out & ready_in;
  // Gating with inflight drops any response that has no matching request,
  // notably one arriving in the first cycle after reset.
  assign push      = imem_rvalid_in & ~redirect_in & inflight;

  assign instr_out = (count != '0) ? head_entry.instr : '0;
  assign pc_out    = (count != '0) ? head_entry.pc    : '0;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      fetch_pc <= RESET_VECTOR;
      resp_pc  <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req_out;
      if (imem_req_out) resp_pc <= fetch_pc;
      if (redirect_in) begin
        fetch_pc <= word_align(redirect_pc_in);
      end else if (imem_req_out) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end
    end
  end

  assign new_entry = '{pc: resp_pc, instr: imem_rdata_in};

  fetch_buf #(
    .DEPTH(BUF_DEPTH)
  ) u_fetch_buf (
    .clk      (clk_in),
    .rst      (rst_in),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_in),
    .wr_entry (new_entry),
    .rd_entry (head_entry),
    .count    (count)
  );

endmodule

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
module tb_if_stage;
  import rv32i_pkg::*;

  localparam logic [31:0] RV      = 32'h0000_0000;
  localparam logic [31:0] WRAP_RV = 32'hFFFF_FFF8;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in;
  logic        imem_rvalid_in;
  logic [31:0] imem_rdata_in;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        ready_in;

  logic         imem_req_out, valid_out;
  logic [31:0]  imem_addr_out, instr_out, pc_out;
  fetch_state_t state_out;

  logic         w_req, w_valid;
  logic [31:0]  w_addr, w_instr, w_pc;
  fetch_state_t w_state;

  if_stage dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
    .imem_rvalid_in(imem_rvalid_in), .imem_rdata_in(imem_rdata_in),
    .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
    .valid_out(valid_out), .ready_in(ready_in),
    .instr_out(instr_out), .pc_out(pc_out), .state_out(state_out)
  );

  if_stage #(.RESET_VECTOR(WRAP_RV)) dut_wrap (
    .clk_in(clk_in), .rst_in(rst_in),
    .imem_req_out(w_req), .imem_addr_out(w_addr),
    .imem_rvalid_in(imem_rvalid_in), .imem_rdata_in(imem_rdata_in),
    .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
    .valid_out(w_valid), .ready_in(ready_in),
    .instr_out(w_instr), .pc_out(w_pc), .state_out(w_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] stream_next = RV;

  logic        mem_req_q  = 1'b0;
  logic [31:0] mem_addr_q = '0;
  logic        last_rst   = 1'b1;

  int          held = 0;
  logic        req_prev = 1'b0;
  logic        rst_prev = 1'b1;
  logic [31:0] req_next = RV;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_pc = '0, prev_instr = '0;
  int          rel_cyc = 0, first_req_rel = -1, first_valid_rel = -1, pop_cnt = 0;
  logic        got_first = 1'b0;
  logic [31:0] first_pc = '0;
  logic [31:0] wrap_addrs[$];

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC3C3_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic rst, input logic rdy, input logic redir,
                             input logic [31:0] tgt);
    @(posedge clk_in);
    #1;
    rst_in         = rst;
    ready_in       = rst ? 1'b0 : rdy;
    redirect_in    = rst ? 1'b0 : redir;
    redirect_pc_in = tgt;
    if (last_rst) begin
      // spurious response in the first cycle after reset
      imem_rvalid_in = 1'b1;
      imem_rdata_in  = $urandom;
    end else begin
      imem_rvalid_in = mem_req_q;
      imem_rdata_in  = mem_req_q ? tag(mem_addr_q) : $urandom;
    end
    last_rst = rst;
    if (rst) begin
      exp_q.delete();
      stream_next = RV;
    end else if (redir) begin
      exp_q.delete();
      stream_next = {tgt[31:2], 2'b00};
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(stream_next);
      stream_next = stream_next + 32'd4;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_in) begin : monitor
    logic pop, push, exp_valid, exp_req, inflight_m;
    logic [31:0] pc_exp;
    int occ;

    rel_cyc = rst_prev ? 0 : rel_cyc + 1;

    check("state_out", 32'(state_out), rst_prev ? 32'(ST_BOOT) : 32'(ST_RUN));
    if (rst_prev) begin
      check("post_rst_pc_out", pc_out, 32'h0);
      check("post_rst_instr_out", instr_out, 32'h0);
    end

    inflight_m = rst_prev ? 1'b0 : req_prev;
    exp_valid  = (held != 0) && !redirect_in;
    check("valid_out", 32'(valid_out), 32'(exp_valid));
    pop = valid_out & ready_in;
    occ = held + int'(inflight_m) - int'(pop);
    exp_req = !rst_prev && !redirect_in && (occ < 2);
    check("imem_req_out", 32'(imem_req_out), 32'(exp_req));
    check("imem_addr_out", imem_addr_out, req_next);

    if (prev_stall && !redirect_in) begin
      check("stall_valid", 32'(valid_out), 32'h1);
      check("stall_pc", pc_out, prev_pc);
      check("stall_instr", instr_out, prev_instr);
    end

    if (pop) begin
      if (exp_q.size() == 0) begin
        check("exp_q_nonempty", 32'h0, 32'h1);
      end else begin
        pc_exp = exp_q.pop_front();
        check("pc_out", pc_out, pc_exp);
        check("instr_out", instr_out, tag(pc_exp));
      end
    end

    if (rst_in) begin
      first_req_rel = -1; first_valid_rel = -1; pop_cnt = 0; got_first = 1'b0;
      wrap_addrs.delete();
    end else begin
      if (imem_req_out && first_req_rel < 0) first_req_rel = rel_cyc;
      if (valid_out && first_valid_rel < 0)  first_valid_rel = rel_cyc;
      if (pop) begin
        pop_cnt++;
        if (!got_first) begin got_first = 1'b1; first_pc = pc_out; end
      end
      if (w_req && wrap_addrs.size() < 3) wrap_addrs.push_back(w_addr);
    end

    push = imem_rvalid_in && !redirect_in && !rst_prev;
    if (rst_in || redirect_in) held = 0;
    else held = held + int'(push) - int'(pop);

    if (rst_in) req_next = RV;
    else if (redirect_in) req_next = {redirect_pc_in[31:2], 2'b00};
    else if (exp_req) req_next = req_next + 32'd4;

    mem_req_q  = imem_req_out;
    mem_addr_q = imem_addr_out;
    req_prev   = imem_req_out;
    prev_stall = valid_out && !ready_in && !rst_in;
    prev_pc    = pc_out;
    prev_instr = instr_out;
    rst_prev   = rst_in;
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [31:0] wa;
    rst_in = 1'b1; ready_in = 1'b0; redirect_in = 1'b0; redirect_pc_in = '0;
    imem_rvalid_in = 1'b0; imem_rdata_in = '0;

    repeat (3) drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);

    // reset release with decode always ready
    repeat (12) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("first_req_cycle", 32'(first_req_rel), 32'd1);
    check("first_valid_cycle", 32'(first_valid_rel), 32'd3);
    check("steady_pops", 32'(pop_cnt), 32'd8);
    check("wrap_req_count", 32'(wrap_addrs.size()), 32'd3);
    if (wrap_addrs.size() == 3) begin
      wa = wrap_addrs[0]; check("wrap_addr0", wa, 32'hFFFF_FFF8);
      wa = wrap_addrs[1]; check("wrap_addr1", wa, 32'hFFFF_FFFC);
      wa = wrap_addrs[2]; check("wrap_addr2", wa, 32'h0000_0000);
    end

    // decode stalled for 6 cycles
    repeat (6) drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk_in); #1;
    check("stall_no_req", 32'(imem_req_out), 32'h0);
    check("stall_held_valid", 32'(valid_out), 32'h1);
    repeat (6) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // redirect with buffer backed up and a response in flight
    drive_cycle(1'b0, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b0, 1'b1, 32'h0000_1003);
    @(negedge clk_in); #1;
    check("redir_valid_low", 32'(valid_out), 32'h0);
    drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk_in); #1;
    check("redir_buf_empty", 32'(valid_out), 32'h0);
    check("redir_req", 32'(imem_req_out), 32'h1);
    check("redir_addr", imem_addr_out, 32'h0000_1000);
    repeat (6) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // back-to-back redirects: the last one wins
    drive_cycle(1'b0, 1'b1, 1'b1, 32'h0000_2000);
    drive_cycle(1'b0, 1'b1, 1'b1, 32'h0000_3006);
    drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk_in); #1;
    check("last_redir_addr", imem_addr_out, 32'h0000_3004);
    repeat (6) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // reset pulse while an instruction is waiting and a response is in flight
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk_in); #1;
    check("post_rst_valid_low", 32'(valid_out), 32'h0);
    repeat (6) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("post_rst_got_pc", 32'(got_first), 32'h1);
    check("post_rst_first_pc", first_pc, RV);

    // redirect in the boot cycle
    drive_cycle(1'b1, 1'b0, 1'b0, 32'h0);
    drive_cycle(1'b0, 1'b1, 1'b1, 32'h0000_4008);
    drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk_in); #1;
    check("boot_redir_addr", imem_addr_out, 32'h0000_4008);
    repeat (6) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);

    // randomized traffic
    for (int i = 0; i < 10000; i++) begin
      logic rs, rd, rdy;
      rs  = ($urandom_range(0, 999) < 3);
      rd  = ($urandom_range(0, 99) < 4);
      rdy = ($urandom_range(0, 99) < 70);
      drive_cycle(rs, rdy, rd, $urandom);
    end
    repeat (4) drive_cycle(1'b0, 1'b1, 1'b0, 32'h0);
    @(negedge clk_in); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
